// File: rtl/ccff_chain_loader_if.sv
// Bitstream beat stream between the SPI/JTAG front end (master) and the
// configuration chain loader (slave): one bit per chain per accepted beat.
interface ccff_chain_loader_if #(
  parameter int NUM_CHAINS = 8
) ();

  logic                  bs_valid;
  logic [NUM_CHAINS-1:0] bs_data;
  logic                  bs_ready;

  modport master (
    output bs_valid,
    output bs_data,
    input  bs_ready
  );

  modport slave (
    input  bs_valid,
    input  bs_data,
    output bs_ready
  );

endinterface

// File: rtl/ccff_chain_loader.sv
// Loads NUM_CHAINS parallel configuration chains: PRST clears them, then each
// accepted beat is shifted in with one generated prog_clk pulse.
// Optional tail check: define CCFF_LOADER_TAILCHK_EN.
module ccff_chain_loader #(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 1024,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  ccff_chain_loader_if.slave    bs,
  output logic [NUM_CHAINS-1:0] ccff_head_o,
  input  logic [NUM_CHAINS-1:0] ccff_tail_i,
  output logic                  prog_clk_o,
  output logic                  prog_reset_no,
  output logic                  config_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int PH_W   = $clog2(CLK_DIV);
  localparam int BEAT_W = $clog2(CHAIN_LEN + 1);
  localparam int RST_W  = $clog2(RST_CYCLES + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CLK_DIV / 2);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CHAIN_LEN - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRST  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [RST_W-1:0]      rst_cnt_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [NUM_CHAINS-1:0] head_q;
  logic                  prog_clk_q;

  logic at_phase0;
  logic hs;
  logic beat_end;
  logic start_go;

  assign at_phase0 = (state_q == SHIFT) && (phase_q == '0);
  assign hs        = at_phase0 && bs.bs_valid;
  assign beat_end  = (state_q == SHIFT) && (phase_q == PH_LAST);
  assign start_go  = ((state_q == IDLE) || (state_q == DONE)) && start_i;

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = PRST;
      end
      PRST: begin
        if (rst_cnt_q == RST_LAST) state_d = SHIFT;
      end
      SHIFT: begin
        if (phase_q == '0) begin
          // Phase 0 holds until the source offers a beat.
          phase_d = hs ? PH_W'(1) : '0;
        end else if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (beat_cnt_q == BEAT_LAST) state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      rst_cnt_q  <= '0;
      beat_cnt_q <= '0;
      head_q     <= '0;
      prog_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      // Decoded from next-state values so prog_clk is a clean flop output.
      prog_clk_q <= (state_d == SHIFT) && (phase_d >= PH_HALF);
      rst_cnt_q  <= (state_q == PRST) ? rst_cnt_q + 1'b1 : '0;

      if (state_q == PRST) begin
        beat_cnt_q <= '0;
      end else if (beat_end) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end

      if (start_go) begin
        head_q <= '0;
      end else if (hs) begin
        head_q <= bs.bs_data;
      end
    end
  end

  assign bs.bs_ready     = at_phase0;
  assign ccff_head_o     = head_q;
  assign prog_clk_o      = prog_clk_q;
  assign prog_reset_no   = (state_q != PRST);
  assign config_enable_o = (state_q == SHIFT);
  assign busy_o          = (state_q == PRST) || (state_q == SHIFT);
  assign done_o          = (state_q == DONE);

`ifdef CCFF_LOADER_TAILCHK_EN
  logic [NUM_CHAINS-1:0] first_q;
  logic                  err_q;

  // Tails are sampled in the last phase of each beat, i.e. just before the
  // prog_clk falling edge; only the final beat should surface the first beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (hs && (beat_cnt_q == '0)) first_q <= bs.bs_data;

      if (state_q == PRST) begin
        err_q <= 1'b0;
      end else if (beat_end) begin
        if (beat_cnt_q == BEAT_LAST) begin
          if (ccff_tail_i != first_q) err_q <= 1'b1;
        end else if (ccff_tail_i != '0) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_tail;
  assign unused_tail = ^ccff_tail_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencer that loads configuration bitstreams into the fabric's parallel configuration chains (ccff_head/ccff_tail) before user operation. It accepts NUM_CHAINS-bit bitstream beats over a valid/ready stream and clears the chains through prog_reset. It shifts one bit per chain per generated prog_clk pulse, then raises done. It sits between the bitstream source (SPI/JTAG front end) and the fpga_top configuration ports.

## Interface
- NUM_CHAINS, 8, number of parallel configuration chains (one bit per chain per beat)
- CHAIN_LEN, 1024, bits per chain (all chains padded to equal length); ≥2
- CLK_DIV, 4, clk_i cycles per prog_clk period; even, ≥2
- RST_CYCLES, 8, clk_i cycles prog_reset_no is held low; ≥1

- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse that starts a load; honoured only in IDLE or DONE
- bs_valid_i  in  1  bitstream beat valid
- bs_data_i  in  NUM_CHAINS  beat; bit k goes to chain k
- bs_ready_o  out  1  beat accepted when bs_valid_i & bs_ready_o
- ccff_head_o  out  NUM_CHAINS  registered chain heads
- ccff_tail_i  in  NUM_CHAINS  chain tails from fabric
- prog_clk_o  out  1  registered configuration clock
- prog_reset_no  out  1  active-low chain reset
- config_enable_o  out  1  high while chains are being loaded
- busy_o  out  1  high in PRST or SHIFT
- done_o  out  1  high in DONE
- err_o  out  1  sticky tail-check error (0 when feature compiled out)

## Operation
- States: IDLE → PRST → SHIFT → DONE; DONE → PRST on start_i.
- IDLE: all outputs at reset values. start_i moves to PRST.
- PRST: prog_reset_no=0 for exactly RST_CYCLES cycles. Clear beat counter and err_o, then go to SHIFT.
- SHIFT: config_enable_o=1. Each beat uses a phase counter 0..CLK_DIV-1:
  - phase 0: bs_ready_o=1. Phase stays 0 until a handshake.
  - On handshake: ccff_head_o <= bs_data_i, and the phase advances.
  - prog_clk_o=1 during phases CLK_DIV/2..CLK_DIV-1, registered, glitch-free.
  - When phase wraps from CLK_DIV-1 to 0, the beat counter increments.
  - After beat CHAIN_LEN completes, go to DONE.
- DONE: done_o=1, config_enable_o=0. ccff_head_o holds the last beat; prog_clk_o=0.
- Beat counter width: $clog2(CHAIN_LEN+1). The counter never wraps; exactly CHAIN_LEN beats are consumed per load.
- bs_valid_i low at phase 0: wait indefinitely; prog_clk_o stays 0.
- start_i during PRST/SHIFT: ignored.
- rst_ni low at any time, including mid-load: immediate return to IDLE with reset values. The fabric is left partially loaded and requires a new start_i.

## Timing
- Reset values:
  - prog_reset_no=1, prog_clk_o=0, ccff_head_o=0
  - config_enable_o=0, bs_ready_o=0
  - busy_o=0, done_o=0, err_o=0
- start_i at cycle t: prog_reset_no low in cycles t+1..t+RST_CYCLES. SHIFT (bs_ready_o=1) starts at t+RST_CYCLES+1.
- Handshake at cycle h:
  - ccff_head_o valid from h+1.
  - prog_clk_o rises at h+CLK_DIV/2 and falls at h+CLK_DIV.
  - Next bs_ready_o at h+CLK_DIV.
- Throughput: one beat per CLK_DIV cycles with continuous valid.
- Minimum load time: RST_CYCLES + CHAIN_LEN·CLK_DIV cycles. done_o rises in the cycle after the last phase.

## Configuration
- CCFF_LOADER_TAILCHK_EN defined: tail check is compiled in. Checks are made at each prog_clk falling edge (end of beat n):
  - Beats 1..CHAIN_LEN-1: ccff_tail_i must be all zero, since PRST cleared the chains.
  - After beat CHAIN_LEN: ccff_tail_i must equal the first beat's data, held in a NUM_CHAINS-bit register.
  - Any mismatch sets err_o, sticky until the next start_i. The load still runs to DONE.
- Not defined: no first-beat register and no compare logic. err_o is tied to 0 and ccff_tail_i is unused.

## Test plan
- Nominal load: CHAIN_LEN=4, CLK_DIV=4, beats 8'h01,8'h02,8'h04,8'h08 with continuous valid.
  - Required: 4 prog_clk pulses; done_o high at cycle RST_CYCLES+17 after start.
  - Required: ccff_head_o=8'h08 after the last beat; config_enable_o high only during SHIFT.
- Stalls: bs_valid_i dropped 10 cycles before beat 3.
  - Required: prog_clk_o stays 0 and bs_ready_o stays 1 during the stall; beat count still 4; no beat lost or duplicated.
- Mid-load reset: rst_ni pulsed low after beat 2.
  - Required: all outputs return to reset values asynchronously.
  - Required: the next start_i re-asserts prog_reset_no low for RST_CYCLES and loads the full 4 beats.
- Tail check (macro on): fabric model with a broken chain 3, tail stuck at 1.
  - Required: err_o=1 after beat 1 and stays set through DONE; a clean reload clears it.
- Tail check pass (macro on): chain model with delay CHAIN_LEN, first beat 8'hA5.
  - Required: ccff_tail_i=8'hA5 after beat 4; err_o stays 0.
- start_i pulsed during SHIFT: ignored. start_i in DONE: restarts the full PRST+SHIFT sequence.
